// File: rtl/control_sequencer_pkg.sv
// Shared types for the BeeF control path: sequencer states, the control
// bundle handed to the datapath, and the SAFE (no side effect) bundle.
package definitions;

   typedef enum logic [1:0] {
      LOAD_S   = 2'd0,
      CORE_S   = 2'd1,
      BRANCH_S = 2'd2,
      HALT_S   = 2'd3
   } STATE;

   typedef enum logic {
      DISABLE = 1'b0,
      ENABLE  = 1'b1
   } CONTROL;

   typedef enum logic {
      MEM_READ  = 1'b0,
      MEM_WRITE = 1'b1
   } MEM_OP;

   typedef enum logic [1:0] {
      PC_INC    = 2'd0,
      PC_JUMP   = 2'd1,
      PC_BRANCH = 2'd2,
      PC_HOLD   = 2'd3
   } PC_SRC;

   localparam int unsigned MEM_ADDR_W = 16;

   typedef struct packed {
      CONTROL                acc_write;
      CONTROL                stack_write;
      CONTROL                head_write;
      CONTROL                cache_write;
      CONTROL                pc_write;
      CONTROL                loader_select;
      CONTROL                halt;
      MEM_OP                 mem_op;
      logic [MEM_ADDR_W-1:0] mem_addr;
      logic [1:0]            mem_src;
      PC_SRC                 pc_src;
      STATE                  state;
   } control_bundle_s;

   // Wire format of a bundle; identical layout to the struct.
   typedef control_bundle_s control_bundle_f;

   // Bundle that performs no write, no halt and a harmless read, tagged
   // with the current state so the state field never lies.
   function automatic control_bundle_f SAFE_BUNDLE(input STATE cur);
      control_bundle_f b;
      b               = '0;
      b.acc_write     = DISABLE;
      b.stack_write   = DISABLE;
      b.head_write    = DISABLE;
      b.cache_write   = DISABLE;
      b.pc_write      = DISABLE;
      b.loader_select = DISABLE;
      b.halt          = DISABLE;
      b.mem_op        = MEM_READ;
      b.pc_src        = PC_INC;
      b.state         = cur;
      return b;
   endfunction

endpackage

// File: rtl/control_sequencer_stall_mask.sv
// Suppresses every architectural write and the halt request of a bundle
// while memory is not ready; the memory access itself stays presented.
module stall_mask
   import definitions::*;
(
   input  control_bundle_f bundle_i,
   input  logic            stall_i,
   output control_bundle_f bundle_o
);

   // Pass the bundle through, killing writes and halt during a stall.
   always_comb begin
      bundle_o = bundle_i;
      if (stall_i) begin
         bundle_o.acc_write   = DISABLE;
         bundle_o.stack_write = DISABLE;
         bundle_o.head_write  = DISABLE;
         bundle_o.cache_write = DISABLE;
         bundle_o.pc_write    = DISABLE;
         bundle_o.halt        = DISABLE;
      end
   end

endmodule

// File: rtl/control_sequencer.sv
// Top-level control selector: owns the STATE register, picks one control
// bundle per cycle for the datapath, applies memory stalls, latches halt
// and counts retired core instructions with saturation.
module control_sequencer
   import definitions::*;
#(
   parameter bit          BOOT_LOAD = 1'b1,
   parameter int unsigned COUNT_W   = 32
) (
   input  logic               clk,
   input  logic               reset,
   input  control_bundle_f    loader_controls,
   input  control_bundle_f    core_controls,
   input  control_bundle_f    branch_controls,
   input  logic               mem_ready,
   output control_bundle_f    controls,
   output STATE               state,
   output logic               halted,
   output logic [COUNT_W-1:0] retired
);

   localparam STATE RESET_STATE = BOOT_LOAD ? LOAD_S : CORE_S;

   STATE               state_q, state_d;
   logic [COUNT_W-1:0] retired_q, retired_d;

   control_bundle_f    selected;
   control_bundle_f    masked;
   logic               active;
   logic               stall;
   logic               retire_en;

   // Running states are the three that hand control to a unit; anything
   // else (HALT_S or an unexpected encoding) is treated as halted.
   assign active = (state_q == LOAD_S) || (state_q == CORE_S) || (state_q == BRANCH_S);
   assign stall  = active && !mem_ready;

   // Bundle mux: one control unit per state, SAFE when halted.
   always_comb begin
      selected = SAFE_BUNDLE(state_q);
      case (state_q)
         LOAD_S:   selected = loader_controls;
         CORE_S:   selected = core_controls;
         BRANCH_S: selected = branch_controls;
         default:  selected = SAFE_BUNDLE(state_q);
      endcase
   end

   stall_mask u_stall_mask (
      .bundle_i (selected),
      .stall_i  (stall),
      .bundle_o (masked)
   );

   // Reset overrides the datapath bundle so an aborted load or scan
   // cannot issue a partial write in the reset cycle.
   always_comb begin
      controls = masked;
      if (reset) begin
         controls = SAFE_BUNDLE(state_q);
      end
   end

   assign halted  = !reset && !active;
   assign state   = state_q;
   assign retired = retired_q;

   // Next state: halt is absorbing, a stall holds, otherwise follow halt
   // request or the selected unit's requested state.
   always_comb begin
      state_d = state_q;
      if (!active) begin
         state_d = HALT_S;
      end else if (!stall) begin
         if (selected.halt == ENABLE) begin
            state_d = HALT_S;
         end else begin
            state_d = selected.state;
         end
      end
   end

   // Only an unstalled core cycle that advances the PC and does not halt
   // counts as a retired instruction; the count sticks at all-ones.
   always_comb begin
      retire_en = (state_q == CORE_S) && !stall &&
                  (selected.pc_write == ENABLE) && (state_d != HALT_S);
      retired_d = retired_q;
      if (retire_en && !(&retired_q)) begin
         retired_d = retired_q + COUNT_W'(1);
      end
   end

   // State register and retired counter with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= RESET_STATE;
         retired_q <= '0;
      end else begin
         state_q   <= state_d;
         retired_q <= retired_d;
      end
   end

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer. dut_a boots into LOAD_S with a
// 4-bit counter; dut_b boots into CORE_S and is used for the reset abort.
module tb_control_sequencer;
  import definitions::*;

  logic            clk;
  logic            reset_a;
  logic            reset_b;
  logic            mem_ready;
  control_bundle_f loader_c;
  control_bundle_f core_c;
  control_bundle_f branch_c;

  control_bundle_f ctrl_a;
  STATE            st_a;
  logic            halted_a;
  logic [3:0]      ret_a;

  control_bundle_f ctrl_b;
  STATE            st_b;
  logic            halted_b;
  logic [31:0]     ret_b;

  int tests;
  int fails;

  control_bundle_f exp_b;

  control_sequencer #(.BOOT_LOAD(1'b1), .COUNT_W(4)) dut_a (
    .clk             (clk),
    .reset           (reset_a),
    .loader_controls (loader_c),
    .core_controls   (core_c),
    .branch_controls (branch_c),
    .mem_ready       (mem_ready),
    .controls        (ctrl_a),
    .state           (st_a),
    .halted          (halted_a),
    .retired         (ret_a)
  );

  control_sequencer #(.BOOT_LOAD(1'b0), .COUNT_W(32)) dut_b (
    .clk             (clk),
    .reset           (reset_b),
    .loader_controls (loader_c),
    .core_controls   (core_c),
    .branch_controls (branch_c),
    .mem_ready       (mem_ready),
    .controls        (ctrl_b),
    .state           (st_b),
    .halted          (halted_b),
    .retired         (ret_b)
  );

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected SAFE bundle, written out from the bundle definition.
  function automatic control_bundle_f safe_exp(input STATE s);
    control_bundle_f b;
    b        = '0;
    b.mem_op = MEM_READ;
    b.state  = s;
    return b;
  endfunction

  function automatic control_bundle_f mk(input logic pcw, input logic accw,
                                         input logic hlt, input STATE s);
    control_bundle_f b;
    b           = '0;
    b.pc_write  = pcw  ? ENABLE : DISABLE;
    b.acc_write = accw ? ENABLE : DISABLE;
    b.halt      = hlt  ? ENABLE : DISABLE;
    b.mem_op    = MEM_READ;
    b.mem_addr  = 16'h0040;
    b.mem_src   = 2'd1;
    b.pc_src    = PC_INC;
    b.state     = s;
    return b;
  endfunction

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    assert (act === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, act, exp);
    end
  endtask

  // Advance past the next rising edge; outputs are then stable.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    tests     = 0;
    fails     = 0;
    reset_a   = 1'b1;
    reset_b   = 1'b1;
    mem_ready = 1'b1;
    loader_c  = mk(1'b0, 1'b1, 1'b0, CORE_S);
    core_c    = mk(1'b1, 1'b1, 1'b0, CORE_S);
    branch_c  = mk(1'b1, 1'b1, 1'b0, BRANCH_S);

    // Reset values
    tick();
    check("reset_state_a", st_a, LOAD_S);
    check("reset_retired_a", ret_a, 4'd0);
    check("reset_halted_a", halted_a, 1'b0);
    check("reset_safe_a", ctrl_a, safe_exp(LOAD_S));
    check("reset_state_b", st_b, CORE_S);
    check("reset_safe_b", ctrl_b, safe_exp(CORE_S));

    // Loader hands over to the core
    reset_a        = 1'b0;
    loader_c       = mk(1'b0, 1'b0, 1'b0, CORE_S);
    loader_c.cache_write = ENABLE;
    #1;
    check("load_ctrl", ctrl_a, loader_c);
    tick();
    check("load_to_core", st_a, CORE_S);
    check("load_no_retire", ret_a, 4'd0);

    // Five retiring core cycles, then a sixth that requests BRANCH_S
    core_c = mk(1'b1, 1'b0, 1'b0, CORE_S);
    #1;
    check("core_ctrl", ctrl_a, core_c);
    repeat (5) tick();
    check("core_retired5", ret_a, 4'd5);
    check("core_state5", st_a, CORE_S);
    core_c = mk(1'b1, 1'b0, 1'b0, BRANCH_S);
    tick();
    check("core_retired6", ret_a, 4'd6);
    check("core_to_branch", st_a, BRANCH_S);

    // Four branch-scan cycles never retire; the last one returns to core
    branch_c = mk(1'b1, 1'b0, 1'b0, BRANCH_S);
    #1;
    check("branch_ctrl", ctrl_a, branch_c);
    repeat (3) tick();
    check("branch_hold_state", st_a, BRANCH_S);
    check("branch_hold_retired", ret_a, 4'd6);
    branch_c = mk(1'b1, 1'b0, 1'b0, CORE_S);
    tick();
    check("branch_to_core", st_a, CORE_S);
    check("branch_no_retire", ret_a, 4'd6);

    // Memory stall with acc_write and pc_write requested
    core_c          = mk(1'b1, 1'b1, 1'b0, CORE_S);
    core_c.mem_op   = MEM_WRITE;
    core_c.mem_addr = 16'h1234;
    core_c.mem_src  = 2'd2;
    mem_ready       = 1'b0;
    exp_b           = core_c;
    exp_b.pc_write  = DISABLE;
    exp_b.acc_write = DISABLE;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("stall_ctrl", ctrl_a, exp_b);
      tick();
      check("stall_state", st_a, CORE_S);
      check("stall_retired", ret_a, 4'd6);
    end
    mem_ready = 1'b1;
    #1;
    check("release_ctrl", ctrl_a, core_c);
    tick();
    check("release_retired", ret_a, 4'd7);

    // Halt requested under stall: stall wins, halt on first ready cycle
    core_c         = mk(1'b1, 1'b0, 1'b1, CORE_S);
    mem_ready      = 1'b0;
    exp_b          = core_c;
    exp_b.pc_write = DISABLE;
    exp_b.halt     = DISABLE;
    #1;
    check("halt_stall_ctrl", ctrl_a, exp_b);
    tick();
    check("halt_stall_state", st_a, CORE_S);
    check("halt_stall_retired", ret_a, 4'd7);
    mem_ready = 1'b1;
    tick();
    check("halt_state", st_a, HALT_S);
    check("halt_halted", halted_a, 1'b1);
    check("halt_no_retire", ret_a, 4'd7);

    // HALT_S is absorbing whatever the units and memory do
    for (int i = 0; i < 10; i++) begin
      mem_ready = i[0];
      loader_c  = mk(1'b1, 1'b1, 1'b0, CORE_S);
      core_c    = mk(1'b1, 1'b1, 1'b0, CORE_S);
      branch_c  = mk(1'b1, 1'b1, 1'b0, LOAD_S);
      #1;
      check("halt_safe_ctrl", ctrl_a, safe_exp(HALT_S));
      tick();
      check("halt_hold_state", st_a, HALT_S);
      check("halt_hold_retired", ret_a, 4'd7);
    end

    // Saturation with a 4-bit counter
    mem_ready = 1'b1;
    reset_a   = 1'b1;
    tick();
    check("rst2_state", st_a, LOAD_S);
    check("rst2_retired", ret_a, 4'd0);
    reset_a  = 1'b0;
    loader_c = mk(1'b0, 1'b0, 1'b0, CORE_S);
    core_c   = mk(1'b1, 1'b0, 1'b0, CORE_S);
    tick();
    check("rst2_core", st_a, CORE_S);
    repeat (14) tick();
    check("sat_14", ret_a, 4'd14);
    tick();
    check("sat_15", ret_a, 4'd15);
    repeat (3) tick();
    check("sat_hold", ret_a, 4'd15);
    check("sat_state", st_a, CORE_S);

    // dut_b: enter BRANCH_S, then a one-cycle reset aborts the scan
    check("b_held_reset_state", st_b, CORE_S);
    check("b_held_reset_retired", ret_b, 32'd0);
    reset_b = 1'b0;
    core_c  = mk(1'b1, 1'b0, 1'b0, BRANCH_S);
    tick();
    check("b_to_branch", st_b, BRANCH_S);
    check("b_retired1", ret_b, 32'd1);
    branch_c             = mk(1'b1, 1'b1, 1'b0, BRANCH_S);
    branch_c.stack_write = ENABLE;
    #1;
    check("b_branch_ctrl", ctrl_b, branch_c);
    reset_b = 1'b1;
    #1;
    check("b_reset_safe", ctrl_b, safe_exp(BRANCH_S));
    check("b_reset_halted", halted_b, 1'b0);
    tick();
    reset_b = 1'b0;
    check("b_reset_state", st_b, CORE_S);
    check("b_reset_retired", ret_b, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Watchdog so the bench always ends
  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/control_sequencer.md
# control_sequencer

Top-level control selector for the BeeF core: holds the processor `STATE` register and routes exactly one control bundle to the datapath each cycle. The candidates come from the loader, the core decoder and the branch-scan control unit. It sits directly upstream of the datapath and downstream of the three control units. It applies memory-ready stalls, latches halt, and keeps a saturating retired-instruction counter.

## Interface
- `BOOT_LOAD`, default 1: reset state is `LOAD_S` when 1, `CORE_S` when 0.
- `COUNT_W`, default 32: width of the retired-instruction counter.
- `clk` in 1: single system clock.
- `reset` in 1: synchronous, active-high reset.
- `loader_controls` in `control_bundle_f`: bundle from the program loader.
- `core_controls` in `control_bundle_f`: bundle from the core instruction decoder.
- `branch_controls` in `control_bundle_f`: bundle from the branch-scan control unit.
- `mem_ready` in 1: memory can complete this cycle's access.
- `controls` out `control_bundle_f`: bundle driven to the datapath.
- `state` out `STATE`: current sequencer state.
- `halted` out 1: high while in `HALT_S`.
- `retired` out `COUNT_W`: instructions retired since reset, saturating.

## Operation
- States: `LOAD_S`, `CORE_S`, `BRANCH_S`, `HALT_S`. The state register is the only state storage besides `retired`.
- Selection, combinational from `state`:
  - `LOAD_S` selects `loader_controls`.
  - `CORE_S` selects `core_controls`.
  - `BRANCH_S` selects `branch_controls`.
  - `HALT_S` selects the SAFE bundle.
- SAFE bundle:
  - `acc_write`, `stack_write`, `head_write`, `cache_write`, `pc_write`, `loader_select`, `halt` all `DISABLE`.
  - `mem_op` is `MEM_READ`.
  - `state` field equals the current state.
  - All other fields take their package-defined zero/default values.
- Stall, when `mem_ready`=0 in `LOAD_S`, `CORE_S` or `BRANCH_S`:
  - `controls` is the selected bundle with all five `*_write` fields forced to `DISABLE` and `halt` forced to `DISABLE`.
  - `mem_op`, `mem_addr` and `mem_src` pass through unchanged, so the access stays presented.
  - State is held and `retired` is held.
- Next state, no stall: if selected `halt`==`ENABLE` then `HALT_S`, else the selected bundle's `state` field.
- `HALT_S` is absorbing: only `reset` leaves it. `mem_ready` is ignored there.
- Retire: `retired` increments by 1 in a cycle where all of the following hold:
  - `state`==`CORE_S`
  - no stall
  - selected `pc_write`==`ENABLE`
  - next state != `HALT_S`
- Saturation: at all-ones, `retired` holds. It never wraps.
- Branch-scan cycles and loader cycles never retire.
- Invalid state encoding, if any, behaves as `HALT_S`.

## Timing
- Reset, sampled at a rising edge, sets:
  - `state` ← `BOOT_LOAD ? LOAD_S : CORE_S`
  - `retired` ← 0
- While `reset` is high, `controls` is the SAFE bundle and `halted`=0, regardless of state.
- Reset mid-branch-scan or mid-load aborts the operation immediately. No partial write is issued in the reset cycle.
- `controls`, `halted` and `state` are combinational from registered state plus inputs. There is zero cycle latency from a control unit to the datapath.
- A state change takes effect at the next rising edge. The new unit's bundle is visible in the cycle after the transition.
- Simultaneous stall and `halt`: the stall wins. Halt is taken on the first non-stalled cycle.
- Simultaneous `halt` and `pc_write` in `CORE_S`: go to `HALT_S` and do not count the instruction.

## Structure
- The `definitions` package holds:
  - the `STATE` enum (`LOAD_S`, `CORE_S`, `BRANCH_S`, `HALT_S`)
  - `control_bundle_s` and `control_bundle_f`
  - the `CONTROL`, `MEM_OP` and `PC_SRC` enums
  - a `SAFE_BUNDLE` constant function taking the current state
- One natural sub-module: `stall_mask`, which is combinational. It takes a bundle and `stall` and returns the bundle with write/halt fields disabled.
- Everything else lives inline: the state register, the 3:1 bundle mux and the saturating counter.

## Test plan
- Reset with `BOOT_LOAD`=1 → `state`=`LOAD_S`, `retired`=0. Loader bundle with `state`=`CORE_S` → `CORE_S` one cycle later.
- `CORE_S`, 5 cycles of a core bundle with `pc_write`=`ENABLE`, then a bundle with `state`=`BRANCH_S` → `retired`=5 (the sixth cycle also retires, giving 6). 4 branch cycles follow with `retired` unchanged, then branch `state`=`CORE_S` returns.
- `mem_ready`=0 for 3 cycles in `CORE_S` with `acc_write` and `pc_write` enabled → the outputs show both `DISABLE` and `mem_op` unchanged. State and `retired` are held. On release, exactly one retire.
- Core `halt`=`ENABLE` while `mem_ready`=0 → stays in `CORE_S`. On `mem_ready`=1 → `HALT_S`, `halted`=1, `retired` unchanged, and the SAFE bundle holds for 10 more cycles.
- Preload `retired` near max (`COUNT_W`=4, 15 retires), then 3 more → `retired` stays 15.
- Assert `reset` for one cycle during `BRANCH_S` with `BOOT_LOAD`=0 → `controls` is SAFE that cycle, then `state`=`CORE_S` and `retired`=0.
